// File: rtl/rr_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: registered one-hot grant, sel and valid
// with a bounded per-owner hold. Define ARB_LOCK_EN to let i_lock suspend the hold limit.
module rr_sel_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_req,
    input  logic             i_lock,
    output logic [3:0]       o_grant,
    output logic [1:0]       o_sel,
    output logic             o_sel_valid,
    output logic [CNT_W-1:0] o_hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t           r_state, w_state_n;
    logic [1:0]       r_ptr, w_ptr_n;
    logic [3:0]       r_grant, w_grant_n;
    logic [1:0]       r_sel, w_sel_n;
    logic             r_valid, w_valid_n;
    logic [CNT_W-1:0] r_hold, w_hold_n;

    logic [3:0]       w_cand;
    logic             w_any;
    logic             w_own;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_lock;

`ifdef ARB_LOCK_EN
    assign w_lock = i_lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = i_lock;
    assign w_lock        = 1'b0;
`endif

    // The current owner is masked out so handover and re-arbitration only see competitors.
    assign w_cand = (r_state == GRANT) ? (i_req & ~r_grant) : i_req;
    assign w_any  = |w_cand;
    assign w_own  = |(i_req & r_grant);

    // Scan from the farthest slot back so the nearest requester to r_ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_cand[w_idx]) w_win = w_idx;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_grant_n = r_grant;
        w_sel_n   = r_sel;
        w_valid_n = r_valid;
        w_hold_n  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_n = GRANT;
                    w_grant_n = 4'b0001 << w_win;
                    w_sel_n   = w_win;
                    w_valid_n = 1'b1;
                    w_hold_n  = '0;
                    w_ptr_n   = w_win + 2'd1;
                end
            end
            GRANT: begin
                if (!w_own) begin
                    if (w_any) begin
                        w_grant_n = 4'b0001 << w_win;
                        w_sel_n   = w_win;
                        w_hold_n  = '0;
                        w_ptr_n   = w_win + 2'd1;
                    end else begin
                        w_state_n = IDLE;
                        w_grant_n = 4'b0000;
                        w_valid_n = 1'b0;
                        w_hold_n  = '0;
                    end
                end else if (r_hold != HOLD_LIM) begin
                    w_hold_n = r_hold + 1'b1;
                end else if (w_any && !w_lock) begin
                    w_grant_n = 4'b0001 << w_win;
                    w_sel_n   = w_win;
                    w_hold_n  = '0;
                    w_ptr_n   = w_win + 2'd1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_grant_n = 4'b0000;
                w_valid_n = 1'b0;
                w_hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_grant <= 4'b0000;
            r_sel   <= 2'd0;
            r_valid <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_grant <= w_grant_n;
            r_sel   <= w_sel_n;
            r_valid <= w_valid_n;
            r_hold  <= w_hold_n;
        end
    end

    assign o_grant     = r_grant;
    assign o_sel       = r_sel;
    assign o_sel_valid = r_valid;
    assign o_hold_cnt  = r_hold;

endmodule
